legal_move_scanner: RTL and testbench
=====================================

# legal_move_scanner

Computes the legal-move mask for the player to move by scanning all 64 squares of the Othello board, one square per clock. Sits directly upstream of the VGA board renderer and drives its `boardM` input. The game controller pulses `start` after every move or turn change. Results are committed atomically at scan end, so the displayed yellow squares never show a partial scan.

## Interface
- `BOARD_DIM`, default 8: board side length. Only 8 is supported. Bit index = `row*8 + col`.
- `clk`, input, 1: global clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: request a scan. Sampled only when `busy`=0.
- `player`, input, 1: side to move. 0 = red (`boardR`), 1 = blue (`boardB`).
- `boardR`, input, 64: red discs.
- `boardB`, input, 64: blue discs.
- `boardM`, output, 64: committed legal-move mask. Bit set = legal square.
- `any_move`, output, 1: OR-reduction of committed `boardM` (0 = player must pass).
- `busy`, output, 1: scan in progress.
- `done`, output, 1: one-cycle pulse when `boardM` has just been updated.

## Operation
- **States**
  - IDLE → SCAN on `start`=1.
  - SCAN → IDLE after square 63.
- **Start**
  - On accepting `start`, snapshot `boardR`, `boardB` and `player` into internal registers.
  - Clear the accumulator and set `idx`=0.
  - Input changes during SCAN have no effect.
- **SCAN step**
  - Each cycle, evaluate square `idx` against the snapshot, write the result into `acc[idx]`, then `idx`++.
- **Legality rule**
  - `own` = the player's board; `opp` = the other board.
  - The square must be empty: `boardR|boardB` bit = 0.
  - At least one of the 8 directions must satisfy: step 1 is `opp`, then zero or more further `opp`, then an `own` disc.
  - A ray that reaches the board edge, or an empty square, before an `own` disc fails.
- **No wrap-around**
  - Row and column bounds are checked on `col`/`row`, never on linear index arithmetic.
  - Stepping east from col 7 leaves the board.
- **Occupancy conflict**
  - A square with both R and B set counts as occupied.
  - It counts as `own` if the own bit is set; otherwise it counts as `opp`.
- **Commit, at the edge ending square 63**
  - `boardM` ← final accumulator.
  - `any_move` ← |accumulator.
  - `done` ← 1; `busy` ← 0.
- **`start` while busy**: ignored. No restart, no queueing.
- **`start` in the `done` cycle**: accepted, because the state is already IDLE.

## Timing
- `start` high in cycle T (`busy`=0) → `busy`=1 in cycles T+1..T+64, which evaluate squares 0..63.
- In cycle T+65:
  - `boardM` and `any_move` show the new result.
  - `done`=1 for exactly that cycle.
  - `busy`=0.
- Fixed latency: 65 cycles from `start` to `done`. Back-to-back scans are possible every 65 cycles.
- `boardM` and `any_move` change only at the commit edge or on reset.
- **Reset values**: `boardM`=0, `any_move`=0, `busy`=0, `done`=0, `idx`=0, state=IDLE.
- **Reset mid-scan**:
  - The scan aborts immediately and the accumulator is discarded.
  - Outputs take their reset values.
  - No `done` is produced.

## Structure
- **Package `othello_pkg`**:
  - `BOARD_SQUARES`=64.
  - `PLAYER_RED`=0, `PLAYER_BLUE`=1.
  - The 8 direction deltas (dcol, drow ∈ {-1,0,1}, excluding 0,0).
  - The square-index helper.
  - The scanner state enum.
- **Sub-module `square_legal_eval`**, combinational:
  - Inputs: `own`, `opp`, `col`, `row`.
  - Output: `legal`.
  - Eight unrolled rays, each up to 6 intermediate steps.
- **Top level**:
  - FSM, `idx` counter, snapshot registers, accumulator and commit logic.

## Test plan
- **Initial position, red to move**
  - Stimulus: R = bits 27, 36; B = bits 28, 35; `player`=0; `start` at T.
  - Response: `done` at T+65 only; `boardM`=0x0000_0804_2010_0000 (bits 20, 29, 34, 43); `any_move`=1.
- **Same board, `player`=1**
  - Response: `boardM`=0x0000_1020_0408_0000 (bits 19, 26, 37, 44).
- **Long ray / no wrap**
  - R bit 0, B bits 1–6, red → `boardM`=0x80.
  - R bit 8, B bit 7, red → `boardM`=0, `any_move`=0. Square 6 must not be flagged through the row wrap.
- **Input changes and `start` during scan**
  - Stimulus: toggle `boardR`, `boardB` and `player` and pulse `start` in cycles T+1..T+64.
  - Response: result equals the T-snapshot result; a single `done` at T+65; `boardM` unchanged until T+65.
- **Reset mid-scan**
  - Stimulus: after a prior scan left `boardM`≠0, start a new scan, then assert `rst_n`=0 at T+30.
  - Response: immediately `boardM`=0, `busy`=0, `any_move`=0; no `done`.
  - A fresh `start` after release gives the correct result after 65 cycles.
- **Back-to-back**
  - Stimulus: assert `start` in the `done` cycle.
  - Response: accepted; second `done` exactly 65 cycles later.

Source files
------------

// File: rtl/othello_pkg.sv
// Shared Othello definitions: board size, player encoding,
// ray direction deltas, square indexing and the scanner state type.
package othello_pkg;

    localparam int BOARD_SQUARES = 64;

    localparam logic PLAYER_RED  = 1'b0;
    localparam logic PLAYER_BLUE = 1'b1;

    // E, SE, S, SW, W, NW, N, NE
    localparam int DCOL [8] = '{ 1,  1,  0, -1, -1, -1,  0,  1};
    localparam int DROW [8] = '{ 0,  1,  1,  1,  0, -1, -1, -1};

    typedef enum logic {
        IDLE,
        SCAN
    } scanState_t;

    function automatic logic [5:0] sqIdx(input int col, input int row);
        return 6'((row * 8) + col);
    endfunction

endpackage

// File: rtl/square_legal_eval.sv
// Combinational legality test of one square: eight rays walked
// outward with explicit row/col bounds so no ray wraps a board edge.
module square_legal_eval
    import othello_pkg::*;
(
    input  logic [BOARD_SQUARES-1:0] own,
    input  logic [BOARD_SQUARES-1:0] opp,
    input  logic [2:0]               col,
    input  logic [2:0]               row,
    output logic                     legal
);

    always_comb begin
        int         c;
        int         r;
        logic       alive;
        logic       seen;
        logic [5:0] s;
        legal = 1'b0;
        c     = 0;
        r     = 0;
        alive = 1'b0;
        seen  = 1'b0;
        s     = sqIdx(int'(col), int'(row));
        if (!(own[s] | opp[s])) begin
            for (int d = 0; d < 8; d++) begin
                alive = 1'b1;
                seen  = 1'b0;
                for (int k = 1; k < 8; k++) begin
                    c = int'(col) + DCOL[d] * k;
                    r = int'(row) + DROW[d] * k;
                    if (alive) begin
                        if (c < 0 || c > 7 || r < 0 || r > 7) begin
                            alive = 1'b0;
                        end else begin
                            s = sqIdx(c, r);
                            // A doubly-occupied square resolves as own first
                            if (own[s]) begin
                                legal = legal | seen;
                                alive = 1'b0;
                            end else if (opp[s]) begin
                                seen = 1'b1;
                            end else begin
                                alive = 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/legal_move_scanner.sv
// Scans a snapshotted board one square per clock and commits the
// legal-move mask atomically when the last square has been evaluated.
module legal_move_scanner
    import othello_pkg::*;
#(
    parameter int BOARD_DIM = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     player,
    input  logic [BOARD_SQUARES-1:0] boardR,
    input  logic [BOARD_SQUARES-1:0] boardB,
    output logic [BOARD_SQUARES-1:0] boardM,
    output logic                     any_move,
    output logic                     busy,
    output logic                     done
);

    localparam int LAST_SQ = BOARD_DIM * BOARD_DIM - 1;

    scanState_t               state;
    scanState_t               nextState;
    logic [5:0]               idx;
    logic [BOARD_SQUARES-1:0] snapR;
    logic [BOARD_SQUARES-1:0] snapB;
    logic                     snapP;
    logic [BOARD_SQUARES-1:0] acc;
    logic [BOARD_SQUARES-1:0] accNext;
    logic [BOARD_SQUARES-1:0] own;
    logic [BOARD_SQUARES-1:0] opp;
    logic                     legal;
    logic                     lastSq;

    assign own    = (snapP == PLAYER_BLUE) ? snapB : snapR;
    assign opp    = (snapP == PLAYER_BLUE) ? snapR : snapB;
    assign lastSq = (idx == 6'(LAST_SQ));

    square_legal_eval u_eval (
        .own   (own),
        .opp   (opp),
        .col   (idx[2:0]),
        .row   (idx[5:3]),
        .legal (legal)
    );

    // Square 63 is folded in here so the commit sees the full result
    always_comb begin
        accNext      = acc;
        accNext[idx] = legal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: if (start)  nextState = SCAN;
            SCAN: if (lastSq) nextState = IDLE;
            default:          nextState = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SCAN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            snapR    <= '0;
            snapB    <= '0;
            snapP    <= PLAYER_RED;
            acc      <= '0;
            boardM   <= '0;
            any_move <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (1'b1)
                (state == IDLE): begin
                    if (start) begin
                        snapR <= boardR;
                        snapB <= boardB;
                        snapP <= player;
                        acc   <= '0;
                        idx   <= '0;
                    end
                end
                (state == SCAN): begin
                    acc <= accNext;
                    idx <= idx + 6'd1;
                    if (lastSq) begin
                        boardM   <= accNext;
                        any_move <= |accNext;
                        done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_legal_move_scanner.sv
// Scoreboard bench: a driver queues expected masks from a rule-level
// reference model; a monitor pops them whenever done is presented.
module tb_legal_move_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        player = 1'b0;
    logic [63:0] boardR = '0;
    logic [63:0] boardB = '0;
    logic [63:0] boardM;
    logic        any_move;
    logic        busy;
    logic        done;

    legal_move_scanner #(.BOARD_DIM(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .player   (player),
        .boardR   (boardR),
        .boardB   (boardB),
        .boardM   (boardM),
        .any_move (any_move),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] mask;
        logic        anyM;
        int          dueCyc;
    } exp_t;

    exp_t        expQ[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] prevM = '0;
    logic        prevRst = 1'b0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Walk each ray while it stays on the board over opponent discs
    function automatic logic [63:0] refMask(input logic [63:0] r,
                                            input logic [63:0] b,
                                            input logic p);
        logic [63:0] own;
        logic [63:0] opp;
        logic [63:0] m;
        int rr;
        int cc;
        int n;
        own = p ? b : r;
        opp = p ? r : b;
        m = '0;
        for (int row = 0; row < 8; row++)
            for (int col = 0; col < 8; col++) begin
                if (r[row*8+col] || b[row*8+col]) continue;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr == 0 && dc == 0) continue;
                        rr = row + dr;
                        cc = col + dc;
                        n = 0;
                        while (rr >= 0 && rr < 8 && cc >= 0 && cc < 8 &&
                               !own[rr*8+cc] && opp[rr*8+cc]) begin
                            n++;
                            rr += dr;
                            cc += dc;
                        end
                        if (n > 0 && rr >= 0 && rr < 8 && cc >= 0 && cc < 8 &&
                            own[rr*8+cc])
                            m[row*8+col] = 1'b1;
                    end
            end
        return m;
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && prevRst && done !== 1'b1)
                check("boardM stable", boardM, prevM);
            if (done === 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected done at cycle %0d", cyc);
                end else begin
                    e = expQ.pop_front();
                    check("done cycle", 64'(cyc), 64'(e.dueCyc));
                    check("boardM", boardM, e.mask);
                    check("any_move", 64'(any_move), 64'(e.anyM));
                    check("busy at done", 64'(busy), 64'd0);
                end
            end else if (expQ.size() > 0 && cyc >= expQ[0].dueCyc) begin
                checks++;
                errors++;
                $display("FAIL missing done: cycle %0d expected done at %0d",
                         cyc, expQ[0].dueCyc);
                void'(expQ.pop_front());
            end
            prevM   = boardM;
            prevRst = rst_n;
        end
    end

    task automatic issue(input logic [63:0] r, input logic [63:0] b,
                         input logic p, input logic [63:0] expM,
                         input bit push, input bit disturb, input int nFollow);
        exp_t e;
        @(negedge clk);
        boardR = r;
        boardB = b;
        player = p;
        start  = 1'b1;
        if (push) begin
            e.mask   = expM;
            e.anyM   = |expM;
            e.dueCyc = cyc + 65;
            expQ.push_back(e);
        end
        for (int i = 0; i < nFollow; i++) begin
            @(negedge clk);
            if (disturb) begin
                boardR = {$urandom, $urandom};
                boardB = {$urandom, $urandom};
                player = 1'($urandom);
                start  = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (expQ.size() != 0 && k < 300) begin
            @(negedge clk);
            start = 1'b0;
            k++;
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain timeout: %0d results outstanding", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic randBoard(input int sel, output logic [63:0] r,
                             output logic [63:0] b);
        r = {$urandom, $urandom} & {$urandom, $urandom};
        b = {$urandom, $urandom} & {$urandom, $urandom} & ~r;
        if (sel % 5 == 0) b = b | (r & {$urandom, $urandom} & {$urandom, $urandom});
    endtask

    initial begin
        logic [63:0] iniR;
        logic [63:0] iniB;
        logic [63:0] r;
        logic [63:0] b;
        logic        p;
        iniR = (64'd1 << 27) | (64'd1 << 36);
        iniB = (64'd1 << 28) | (64'd1 << 35);

        repeat (3) @(negedge clk);
        check("reset boardM", boardM, 64'd0);
        check("reset any_move", 64'(any_move), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // Directed cases, each started in the previous done cycle
        issue(iniR, iniB, 1'b0, 64'h0000_0804_2010_0000, 1, 0, 64);
        issue(iniR, iniB, 1'b1, 64'h0000_1020_0408_0000, 1, 0, 64);
        issue(64'h1, 64'h7E, 1'b0, 64'h80, 1, 0, 64);
        issue(64'h100, 64'h80, 1'b0, 64'h0, 1, 0, 64);
        drain();

        randBoard(1, r, b);
        issue(r, b, 1'b1, refMask(r, b, 1'b1), 1, 1, 64);
        idle(1);
        drain();

        issue(iniR, iniB, 1'b0, refMask(iniR, iniB, 1'b0), 1, 0, 64);
        drain();
        issue(iniR, iniB, 1'b1, '0, 0, 0, 29);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid-reset boardM", boardM, 64'd0);
        check("mid-reset busy", 64'(busy), 64'd0);
        check("mid-reset any_move", 64'(any_move), 64'd0);
        idle(3);
        rst_n = 1'b1;
        idle(2);
        issue(iniR, iniB, 1'b1, refMask(iniR, iniB, 1'b1), 1, 0, 64);
        drain();

        for (int t = 0; t < 20; t++) begin
            randBoard(t, r, b);
            p = 1'($urandom);
            issue(r, b, p, refMask(r, b, p), 1, (t % 4 == 3), 64);
            if (t % 2 == 0) idle($urandom_range(1, 3));
        end
        idle(3);
        drain();
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout");
        $fatal(1);
    end

endmodule
